fd_pipe_reg: RTL and testbench



---
 rtl/fd_pipe_reg_pkg.sv | 18 +
 rtl/fd_pipe_reg_sat_counter.sv | 36 +++
 rtl/fd_pipe_reg.sv | 122 ++++++++++++
 tb/tb_fd_pipe_reg.sv | 268 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/fd_pipe_reg_pkg.sv
// Shared definitions for the fetch/decode stage registers: default widths,
// the NOP encoding used for bubbles, and the common pipeline payload type.
package fd_pipe_reg_pkg;

  localparam int FD_PC_W   = 64;
  localparam int FD_INST_W = 32;

  // addi x0,x0,0 -- the canonical RISC-V NOP
  localparam logic [31:0] FD_NOP_INST = 32'h0000_0013;

  // Payload carried between stage registers; later stages reuse this shape.
  typedef struct packed {
    logic                 valid;
    logic [FD_PC_W-1:0]   pc;
    logic [FD_INST_W-1:0] inst;
  } pipe_payload_t;

endpackage

// File: rtl/fd_pipe_reg_sat_counter.sv
// Saturating event counter: adds 0..3 per cycle and sticks at all-ones.
// Only reset clears it, so software never sees a wrapped value.
module sat_counter #(
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [1:0]       inc,
  output logic [CNT_W-1:0] cnt
);

  logic [CNT_W-1:0] cnt_q;
  logic [CNT_W-1:0] cnt_d;
  logic [CNT_W+1:0] sum;

  // Widen by two bits so cnt + 3 can never overflow before the clamp.
  always_comb begin
    sum   = {2'b00, cnt_q} + {{CNT_W{1'b0}}, inc};
    cnt_d = sum[CNT_W-1:0];
    if (sum > {2'b00, {CNT_W{1'b1}}}) begin
      cnt_d = {CNT_W{1'b1}};
    end
  end

  // Counter register, cleared only by reset.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      cnt_q <= '0;
    end else begin
      cnt_q <= cnt_d;
    end
  end

  assign cnt = cnt_q;

endmodule

// File: rtl/fd_pipe_reg.sv
// Fetch-to-decode pipeline register with valid/ready intake, a one-entry
// skid slot that catches fetch data arriving during a hold, flush-to-bubble,
// and saturating counters for killed instructions and delivered bubbles.
module fd_pipe_reg
  import fd_pipe_reg_pkg::*;
#(
  parameter int                 PC_W     = FD_PC_W,
  parameter int                 INST_W   = FD_INST_W,
  parameter logic [INST_W-1:0]  NOP_INST = INST_W'(FD_NOP_INST),
  parameter int                 CNT_W    = 16
) (
  input  logic              clk,
  input  logic              rst,
  input  logic              in_valid,
  output logic              in_ready,
  input  logic [PC_W-1:0]   in_pc,
  input  logic [INST_W-1:0] in_inst,
  input  logic              stall,
  input  logic              waiting,
  input  logic              flush,
  output logic              out_valid,
  output logic [PC_W-1:0]   out_pc,
  output logic [INST_W-1:0] out_inst,
  output logic [CNT_W-1:0]  kill_cnt,
  output logic [CNT_W-1:0]  bubble_cnt
);

  logic              out_valid_q, out_valid_d;
  logic [PC_W-1:0]   out_pc_q,    out_pc_d;
  logic [INST_W-1:0] out_inst_q,  out_inst_d;
  logic              skid_valid_q, skid_valid_d;
  logic [PC_W-1:0]   skid_pc_q,    skid_pc_d;
  logic [INST_W-1:0] skid_inst_q,  skid_inst_d;

  logic       hold;
  logic       accept;
  logic [1:0] kill_inc;
  logic       bubble_evt;

  // Ready comes straight from the skid flop so upstream sees no comb path.
  assign in_ready = !skid_valid_q;
  assign hold     = stall | waiting;
  assign accept   = in_valid & in_ready;

  // Next-state selection: flush beats hold, hold beats advance.
  always_comb begin
    out_valid_d  = out_valid_q;
    out_pc_d     = out_pc_q;
    out_inst_d   = out_inst_q;
    skid_valid_d = skid_valid_q;
    skid_pc_d    = skid_pc_q;
    skid_inst_d  = skid_inst_q;
    kill_inc     = 2'd0;
    bubble_evt   = 1'b0;

    if (flush) begin
      out_valid_d  = 1'b0;
      out_inst_d   = NOP_INST;
      skid_valid_d = 1'b0;
      kill_inc     = {1'b0, out_valid_q} + {1'b0, skid_valid_q} + {1'b0, accept};
    end else if (hold) begin
      if (accept) begin
        skid_valid_d = 1'b1;
        skid_pc_d    = in_pc;
        skid_inst_d  = in_inst;
      end
    end else begin
      if (skid_valid_q) begin
        out_valid_d  = 1'b1;
        out_pc_d     = skid_pc_q;
        out_inst_d   = skid_inst_q;
        skid_valid_d = 1'b0;
      end else if (accept) begin
        out_valid_d = 1'b1;
        out_pc_d    = in_pc;
        out_inst_d  = in_inst;
      end else begin
        out_valid_d = 1'b0;
        out_inst_d  = NOP_INST;
        bubble_evt  = 1'b1;
      end
    end
  end

  // Output and skid registers; reset leaves an empty pipe showing a NOP.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      out_valid_q  <= 1'b0;
      out_pc_q     <= '0;
      out_inst_q   <= NOP_INST;
      skid_valid_q <= 1'b0;
      skid_pc_q    <= '0;
      skid_inst_q  <= NOP_INST;
    end else begin
      out_valid_q  <= out_valid_d;
      out_pc_q     <= out_pc_d;
      out_inst_q   <= out_inst_d;
      skid_valid_q <= skid_valid_d;
      skid_pc_q    <= skid_pc_d;
      skid_inst_q  <= skid_inst_d;
    end
  end

  assign out_valid = out_valid_q;
  assign out_pc    = out_pc_q;
  assign out_inst  = out_inst_q;

  sat_counter #(.CNT_W(CNT_W)) u_kill_cnt (
    .clk (clk),
    .rst (rst),
    .inc (kill_inc),
    .cnt (kill_cnt)
  );

  sat_counter #(.CNT_W(CNT_W)) u_bubble_cnt (
    .clk (clk),
    .rst (rst),
    .inc ({1'b0, bubble_evt}),
    .cnt (bubble_cnt)
  );

endmodule

// File: tb/tb_fd_pipe_reg.sv
// Directed bench for fd_pipe_reg: reset, streaming, skid capture, flush and
// counter saturation (a second instance with 2-bit counters).
module tb_fd_pipe_reg;

  localparam int PC_W   = 64;
  localparam int INST_W = 32;
  localparam int CNT_W  = 16;
  localparam logic [INST_W-1:0] NOP = 32'h0000_0013;

  logic              clk = 1'b0;
  logic              rst = 1'b1;
  logic              in_valid = 1'b0;
  logic              in_ready;
  logic [PC_W-1:0]   in_pc = '0;
  logic [INST_W-1:0] in_inst = '0;
  logic              stall = 1'b0;
  logic              waiting = 1'b0;
  logic              flush = 1'b0;
  logic              out_valid;
  logic [PC_W-1:0]   out_pc;
  logic [INST_W-1:0] out_inst;
  logic [CNT_W-1:0]  kill_cnt;
  logic [CNT_W-1:0]  bubble_cnt;

  logic              sat_in_valid = 1'b0;
  logic              sat_in_ready;
  logic [PC_W-1:0]   sat_in_pc = '0;
  logic [INST_W-1:0] sat_in_inst = '0;
  logic              sat_stall = 1'b0;
  logic              sat_waiting = 1'b0;
  logic              sat_flush = 1'b0;
  logic              sat_out_valid;
  logic [PC_W-1:0]   sat_out_pc;
  logic [INST_W-1:0] sat_out_inst;
  logic [1:0]        sat_kill_cnt;
  logic [1:0]        sat_bubble_cnt;

  int checks = 0;
  int errors = 0;

  always #5 clk = ~clk;

  fd_pipe_reg #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(CNT_W)) dut (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (in_valid),
    .in_ready   (in_ready),
    .in_pc      (in_pc),
    .in_inst    (in_inst),
    .stall      (stall),
    .waiting    (waiting),
    .flush      (flush),
    .out_valid  (out_valid),
    .out_pc     (out_pc),
    .out_inst   (out_inst),
    .kill_cnt   (kill_cnt),
    .bubble_cnt (bubble_cnt)
  );

  fd_pipe_reg #(.PC_W(PC_W), .INST_W(INST_W), .NOP_INST(NOP), .CNT_W(2)) dut_sat (
    .clk        (clk),
    .rst        (rst),
    .in_valid   (sat_in_valid),
    .in_ready   (sat_in_ready),
    .in_pc      (sat_in_pc),
    .in_inst    (sat_in_inst),
    .stall      (sat_stall),
    .waiting    (sat_waiting),
    .flush      (sat_flush),
    .out_valid  (sat_out_valid),
    .out_pc     (sat_out_pc),
    .out_inst   (sat_out_inst),
    .kill_cnt   (sat_kill_cnt),
    .bubble_cnt (sat_bubble_cnt)
  );

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    in_valid = 1'b0;
    stall    = 1'b0;
    waiting  = 1'b0;
    flush    = 1'b0;
    rst      = 1'b1;
    tick();
    rst      = 1'b0;
  endtask

  task automatic test_reset();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h200; in_inst = 32'hAAAA_0001;
    tick();
    stall = 1'b1; in_pc = 64'h204; in_inst = 32'hAAAA_0002;
    tick();
    checks++;
    if (in_ready !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_pre_skid_full: in_ready=%b expected 0", in_ready);
    end
    #2;
    rst = 1'b1;
    #1;
    checks++;
    if (out_valid !== 1'b0) begin
      errors++; $display("[TB] FAIL reset_out_valid: got %b expected 0", out_valid);
    end
    checks++;
    if (out_inst !== NOP) begin
      errors++; $display("[TB] FAIL reset_out_inst: got %h expected %h", out_inst, NOP);
    end
    checks++;
    if (out_pc !== 64'h0) begin
      errors++; $display("[TB] FAIL reset_out_pc: got %h expected 0", out_pc);
    end
    checks++;
    if (in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL reset_in_ready: got %b expected 1", in_ready);
    end
    checks++;
    if (kill_cnt !== 16'd0 || bubble_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL reset_counters: kill=%0d bubble=%0d expected 0 0", kill_cnt, bubble_cnt);
    end
    tick();
    rst = 1'b0; stall = 1'b0; in_valid = 1'b0;
  endtask

  task automatic test_streaming();
    logic [PC_W-1:0]   pcs   [3];
    logic [INST_W-1:0] insts [3];
    pcs[0] = 64'h100; pcs[1] = 64'h104; pcs[2] = 64'h108;
    insts[0] = 32'h0010_0093; insts[1] = 32'h0020_0113; insts[2] = 32'h0030_0193;
    do_reset();
    for (int i = 0; i < 3; i++) begin
      in_valid = 1'b1; in_pc = pcs[i]; in_inst = insts[i];
      tick();
      checks++;
      if (out_valid !== 1'b1 || out_pc !== pcs[i] || out_inst !== insts[i]) begin
        errors++; $display("[TB] FAIL stream_%0d: got v=%b pc=%h inst=%h expected v=1 pc=%h inst=%h",
                           i, out_valid, out_pc, out_inst, pcs[i], insts[i]);
      end
    end
    checks++;
    if (bubble_cnt !== 16'd0) begin
      errors++; $display("[TB] FAIL stream_bubble: got %0d expected 0", bubble_cnt);
    end
    in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 64'h108 || bubble_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL stream_idle: got v=%b pc=%h inst=%h bub=%0d expected v=0 pc=108 inst=%h bub=1",
                         out_valid, out_pc, out_inst, bubble_cnt, NOP);
    end
  endtask

  task automatic test_stall_capture();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h100; in_inst = 32'h1111_0000;
    tick();
    stall = 1'b1; in_pc = 64'h104; in_inst = 32'h1111_0004;
    for (int i = 0; i < 3; i++) begin
      tick();
      checks++;
      if (in_ready !== 1'b0 || out_valid !== 1'b1 || out_pc !== 64'h100 || out_inst !== 32'h1111_0000) begin
        errors++; $display("[TB] FAIL stall_hold_%0d: got rdy=%b v=%b pc=%h inst=%h expected rdy=0 v=1 pc=100 inst=11110000",
                           i, in_ready, out_valid, out_pc, out_inst);
      end
    end
    stall = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h104 || out_inst !== 32'h1111_0004 || in_ready !== 1'b1) begin
      errors++; $display("[TB] FAIL stall_release: got v=%b pc=%h inst=%h rdy=%b expected v=1 pc=104 inst=11110004 rdy=1",
                         out_valid, out_pc, out_inst, in_ready);
    end
    tick();
    checks++;
    if (out_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL stall_after: got v=%b bub=%0d expected v=0 bub=1", out_valid, bubble_cnt);
    end
  endtask

  task automatic test_flush_full();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h100; in_inst = 32'h2222_0000;
    tick();
    stall = 1'b1; in_pc = 64'h104; in_inst = 32'h2222_0004;
    tick();
    flush = 1'b1;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 64'h100 || in_ready !== 1'b1 || kill_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL flush_full: got v=%b pc=%h inst=%h rdy=%b kill=%0d expected v=0 pc=100 inst=%h rdy=1 kill=2",
                         out_valid, out_pc, out_inst, in_ready, kill_cnt, NOP);
    end
    flush = 1'b0; stall = 1'b0; in_pc = 64'h108; in_inst = 32'h2222_0008;
    tick();
    checks++;
    if (out_valid !== 1'b1 || out_pc !== 64'h108 || kill_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL flush_refill: got v=%b pc=%h kill=%0d expected v=1 pc=108 kill=2",
                         out_valid, out_pc, kill_cnt);
    end
    flush = 1'b1; in_pc = 64'h10C; in_inst = 32'h2222_000C;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h108 || kill_cnt !== 16'd4) begin
      errors++; $display("[TB] FAIL flush_accept: got v=%b pc=%h kill=%0d expected v=0 pc=108 kill=4",
                         out_valid, out_pc, kill_cnt);
    end
    flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_pc !== 64'h108 || bubble_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL flush_discard: got v=%b pc=%h bub=%0d expected v=0 pc=108 bub=1",
                         out_valid, out_pc, bubble_cnt);
    end
  endtask

  task automatic test_flush_beats_hold();
    do_reset();
    in_valid = 1'b1; in_pc = 64'h300; in_inst = 32'h3333_0000;
    tick();
    waiting = 1'b1; flush = 1'b1; in_pc = 64'h304; in_inst = 32'h3333_0004;
    tick();
    checks++;
    if (out_valid !== 1'b0 || out_inst !== NOP || out_pc !== 64'h300 || in_ready !== 1'b1 || kill_cnt !== 16'd2) begin
      errors++; $display("[TB] FAIL flush_hold: got v=%b pc=%h inst=%h rdy=%b kill=%0d expected v=0 pc=300 inst=%h rdy=1 kill=2",
                         out_valid, out_pc, out_inst, in_ready, kill_cnt, NOP);
    end
    waiting = 1'b0; flush = 1'b0; in_valid = 1'b0;
    tick();
    checks++;
    if (out_valid !== 1'b0 || bubble_cnt !== 16'd1) begin
      errors++; $display("[TB] FAIL flush_hold_noskid: got v=%b bub=%0d expected v=0 bub=1", out_valid, bubble_cnt);
    end
  endtask

  task automatic test_saturation();
    int expect_cnt;
    do_reset();
    checks++;
    if (sat_bubble_cnt !== 2'd0) begin
      errors++; $display("[TB] FAIL sat_start: got %0d expected 0", sat_bubble_cnt);
    end
    for (int k = 1; k <= 6; k++) begin
      tick();
      expect_cnt = (k > 3) ? 3 : k;
      checks++;
      if (sat_bubble_cnt !== expect_cnt[1:0]) begin
        errors++; $display("[TB] FAIL sat_cycle_%0d: got %0d expected %0d", k, sat_bubble_cnt, expect_cnt);
      end
    end
  endtask

  initial begin
    $display("[TB] starting fd_pipe_reg bench");
    test_reset();
    test_streaming();
    test_stall_capture();
    test_flush_full();
    test_flush_beats_hold();
    test_saturation();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
